// File: rtl/uart_byte_rx_if.sv
// ============================================================================
//  Module      : uart_byte_rx_if
//  Description : Byte-output bundle of the UART receiver. The receiver drives
//                it through the master modport; the downstream pairing stage
//                reads it through the slave modport.
//  Signals     : po_data   [7:0]  last good byte, LSB received first
//                po_flag          one-cycle strobe, po_data updated this cycle
//                frame_err        one-cycle strobe, stop bit sampled low
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_byte_rx_if;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  modport master (
    output po_data,
    output po_flag,
    output frame_err
  );

  modport slave (
    input po_data,
    input po_flag,
    input frame_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
//  Module      : uart_byte_rx
//  Description : 8N1 UART receiver. Recovers bytes from the asynchronous
//                serial line and presents each one with a one-cycle strobe.
//                Frames whose stop bit is sampled low are discarded and
//                reported with a one-cycle frame_err pulse.
//  Ports       : sys_clk         in   system clock, rising edge
//                sys_rst         in   synchronous, active-high reset
//                rx              in   serial line, idle high, asynchronous
//                byte_if.master  out  po_data / po_flag / frame_err
//  Parameters  : CLK_FREQ   system clock frequency in Hz
//                BAUD_RATE  line rate in bit/s (CLK_FREQ/BAUD_RATE >= 4)
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_byte_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  wire logic       sys_clk,
  input  wire logic       sys_rst,
  input  wire logic       rx,
  uart_byte_rx_if.master  byte_if
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

  localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] C_BAUD_HALF = CNT_W'(BAUD_CNT / 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       po_data_q;
  logic             po_flag_q;
  logic             frame_err_q;

  logic             w_fall;
  logic             w_sample;

  // Synchroniser and edge registers reset to 0, so a line that is already
  // low when reset releases never looks like a falling edge.
  assign w_fall   = rx_prev_q & ~rx_sync_q;
  assign w_sample = (baud_cnt_q == C_BAUD_HALF);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b0;
      rx_sync_q   <= 1'b0;
      rx_prev_q   <= 1'b0;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      po_data_q   <= 8'h00;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;

      // Free-running bit timer while a frame is in progress.
      if (state_q == S_IDLE) begin
        baud_cnt_q <= '0;
      end else if (baud_cnt_q == C_BAUD_LAST) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (w_fall) begin
            state_q    <= S_START;
            baud_cnt_q <= '0;
          end
        end

        S_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (w_sample) begin
            if (!rx_sync_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end else begin
              state_q   <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (w_sample) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        S_STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a following
          // start edge, so frames may arrive with no idle gap.
          if (w_sample) begin
            if (rx_sync_q) begin
              po_data_q <= shift_q;
              po_flag_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end

        S_BREAK: begin
          // Line held low after a bad stop bit: wait for it to recover.
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_if.po_data   = po_data_q;
  assign byte_if.po_flag   = po_flag_q;
  assign byte_if.frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// ============================================================================
//  Module      : tb_uart_byte_rx
//  Description : Self-checking bench for uart_byte_rx (BAUD_CNT = 10).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_byte_rx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CLK_NS    = 10;
  localparam int BIT_NS    = CLK_NS * (CLK_FREQ / BAUD_RATE);

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic rx      = 1'b1;

  always #(CLK_NS/2) sys_clk = ~sys_clk;

  uart_byte_rx_if bus ();

  uart_byte_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx      (rx),
    .byte_if (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Event recorder: what the DUT emitted, and when (time of the clock edge).
  logic [7:0] got_q[$];
  longint     got_t[$];
  int         err_cnt     = 0;
  int         overlap_cnt = 0;
  int         wide_cnt    = 0;
  logic       prev_flag   = 1'b0;
  logic       prev_err    = 1'b0;

  // Last good byte according to the bench's own model.
  logic [7:0] exp_last = 8'h00;

  always @(posedge sys_clk) begin
    #1;
    if (bus.po_flag === 1'b1) begin
      got_q.push_back(bus.po_data);
      got_t.push_back($time - 1);
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.po_flag === 1'b1 && bus.frame_err === 1'b1) overlap_cnt++;
    if ((bus.po_flag === 1'b1 && prev_flag) || (bus.frame_err === 1'b1 && prev_err)) wide_cnt++;
    prev_flag = (bus.po_flag === 1'b1);
    prev_err  = (bus.frame_err === 1'b1);
  end

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    err_cnt     = 0;
    overlap_cnt = 0;
    wide_cnt    = 0;
  endtask

  // Drive one full frame starting now; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    rx      = 1'b1;
    idle_clks(4);
    tests_run++;
    if (bus.po_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_po_data: got %h expected 00", bus.po_data);
    end
    tests_run++;
    if (bus.po_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_po_flag: got %b expected 0", bus.po_flag);
    end
    tests_run++;
    if (bus.frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
    end
    sys_rst = 1'b0;
    idle_clks(5);
    exp_last = 8'h00;
  endtask

  task automatic test_single();
    longint t0;
    longint lat;
    clear_mon();
    @(negedge sys_clk);
    t0 = $time;
    send_frame(8'hA5, 1'b1, BIT_NS);
    idle_clks(20);
    tests_run++;
    if (got_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() >= 1) begin
      exp_last = 8'hA5;
      tests_run++;
      if (got_q[0] !== 8'hA5) begin
        tests_failed++;
        $display("FAIL single_data: got %h expected a5", got_q[0]);
      end
      // Clocks counted from the first rising edge after the line falls.
      lat = (got_t[0] - (t0 + CLK_NS/2)) / CLK_NS;
      tests_run++;
      if (lat < 95 || lat > 98) begin
        tests_failed++;
        $display("FAIL single_latency: got %0d clocks expected 95..98", lat);
      end
    end
    tests_run++;
    if (err_cnt != 0 || overlap_cnt != 0 || wide_cnt != 0) begin
      tests_failed++;
      $display("FAIL single_pulses: got err=%0d overlap=%0d wide=%0d expected 0/0/0",
               err_cnt, overlap_cnt, wide_cnt);
    end
    tests_run++;
    if (bus.po_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_hold: got %h expected a5", bus.po_data);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    @(negedge sys_clk);
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    idle_clks(20);
    tests_run++;
    if (got_q.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d pulses expected 2", got_q.size());
    end
    if (got_q.size() == 2) begin
      exp_last = 8'hFF;
      tests_run++;
      if (got_q[0] !== 8'h00 || got_q[1] !== 8'hFF) begin
        tests_failed++;
        $display("FAIL b2b_data: got %h %h expected 00 ff", got_q[0], got_q[1]);
      end
      tests_run++;
      if (got_t[1] - got_t[0] != 100 * CLK_NS) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d clocks expected 100",
                 (got_t[1] - got_t[0]) / CLK_NS);
      end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge sys_clk);
    rx = 1'b0;
    idle_clks(3);
    rx = 1'b1;
    idle_clks(30);
    tests_run++;
    if (got_q.size() != 0 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL glitch_quiet: got flags=%0d errs=%0d expected 0/0", got_q.size(), err_cnt);
    end
    clear_mon();
    @(negedge sys_clk);
    send_frame(8'h3C, 1'b1, BIT_NS);
    idle_clks(20);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      tests_failed++;
      $display("FAIL glitch_next: got %0d pulses first=%h expected 1 pulse 3c",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    exp_last = 8'h3C;
  endtask

  task automatic test_frame_err();
    clear_mon();
    @(negedge sys_clk);
    send_frame(8'h5A, 1'b0, BIT_NS);
    #(30 * CLK_NS);
    rx = 1'b1;
    idle_clks(20);
    tests_run++;
    if (err_cnt != 1 || got_q.size() != 0 || overlap_cnt != 0 || wide_cnt != 0) begin
      tests_failed++;
      $display("FAIL ferr_pulses: got errs=%0d flags=%0d overlap=%0d wide=%0d expected 1/0/0/0",
               err_cnt, got_q.size(), overlap_cnt, wide_cnt);
    end
    tests_run++;
    if (bus.po_data !== exp_last) begin
      tests_failed++;
      $display("FAIL ferr_hold: got %h expected %h", bus.po_data, exp_last);
    end
    clear_mon();
    @(negedge sys_clk);
    send_frame(8'hC3, 1'b1, BIT_NS);
    idle_clks(20);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 8'hC3 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL ferr_next: got %0d pulses first=%h errs=%0d expected 1 pulse c3",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, err_cnt);
    end
    exp_last = 8'hC3;
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] b;
    b = 8'h81;
    clear_mon();
    @(negedge sys_clk);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS/2);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    idle_clks(2);
    sys_rst = 1'b0;
    rx      = 1'b1;
    exp_last = 8'h00;
    idle_clks(150);
    tests_run++;
    if (got_q.size() != 0 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: got flags=%0d errs=%0d expected 0/0", got_q.size(), err_cnt);
    end
    tests_run++;
    if (bus.po_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_data: got %h expected 00", bus.po_data);
    end
    clear_mon();
    @(negedge sys_clk);
    send_frame(8'h81, 1'b1, BIT_NS);
    idle_clks(20);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      tests_failed++;
      $display("FAIL rst_mid_next: got %0d pulses first=%h expected 1 pulse 81",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    exp_last = 8'h81;

    // Line stuck low across reset release must not be taken as a start bit.
    clear_mon();
    @(negedge sys_clk);
    rx      = 1'b0;
    sys_rst = 1'b1;
    idle_clks(2);
    sys_rst = 1'b0;
    exp_last = 8'h00;
    idle_clks(50);
    tests_run++;
    if (got_q.size() != 0 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL rst_low_quiet: got flags=%0d errs=%0d expected 0/0", got_q.size(), err_cnt);
    end
    rx = 1'b1;
    idle_clks(5);
    send_frame(8'h7E, 1'b1, BIT_NS);
    idle_clks(20);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 8'h7E || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL rst_low_next: got %0d pulses first=%h errs=%0d expected 1 pulse 7e",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, err_cnt);
    end
    exp_last = 8'h7E;
  endtask

  task automatic test_tolerance();
    int periods[2];
    periods[0] = 103;   // sender 3% slow
    periods[1] = 97;    // sender 3% fast
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      @(negedge sys_clk);
      send_frame(8'h96, 1'b1, periods[k]);
      idle_clks(20);
      tests_run++;
      if (got_q.size() != 1 || got_q[0] !== 8'h96 || err_cnt != 0) begin
        tests_failed++;
        $display("FAIL tol_%0dns: got %0d pulses first=%h errs=%0d expected 1 pulse 96",
                 periods[k], got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, err_cnt);
      end
      exp_last = 8'h96;
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] b;
    logic       bad;
    int         gap;
    exp_err = 0;
    clear_mon();
    @(negedge sys_clk);
    for (int n = 0; n < 40; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 6) == 0);
      gap = $urandom_range(0, 25);
      send_frame(b, ~bad, BIT_NS);
      if (bad) begin
        exp_err++;
        #($urandom_range(10, 30) * CLK_NS);
        rx = 1'b1;
        if (gap < 3) gap = 3;
      end else begin
        exp_q.push_back(b);
        exp_last = b;
      end
      if (gap > 0) #(gap * CLK_NS);
    end
    idle_clks(20);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (err_cnt != exp_err) begin
      tests_failed++;
      $display("FAIL rand_errs: got %0d expected %0d", err_cnt, exp_err);
    end
    tests_run++;
    if (overlap_cnt != 0 || wide_cnt != 0) begin
      tests_failed++;
      $display("FAIL rand_pulse_shape: got overlap=%0d wide=%0d expected 0/0", overlap_cnt, wide_cnt);
    end
    tests_run++;
    if (bus.po_data !== exp_last) begin
      tests_failed++;
      $display("FAIL rand_hold: got %h expected %h", bus.po_data, exp_last);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_frame_reset();
    test_tolerance();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
